// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - 640x480@60 Hz VGA raster timing generator
//
// Purpose:
//   Free-running horizontal/vertical counters with registered decode of scan
//   coordinates, visible-area flag, active-low syncs and line/frame strobes.
//   Every output is a flop loaded from the counter value of the same edge, so
//   ports lag the internal counters by exactly one clock.
//
// Ports:
//   vga_clk      in   1   pixel clock, the only clock
//   reset_n      in   1   asynchronous active-low reset
//   DrawX        out  10  current pixel column, 0..H_TOTAL-1
//   DrawY        out  10  current line, 0..V_TOTAL-1
//   blank        out  1   1 = visible pixel, 0 = porch/sync
//   hs           out  1   horizontal sync, active low
//   vs           out  1   vertical sync, active low
//   line_start   out  1   1-clk pulse when DrawX == 0
//   frame_start  out  1   1-clk pulse when DrawX == 0 && DrawY == 0
//
// Configuration macro:
//   VGA_SYNC_DELAY_EN - adds one register stage (reset value 1) on hs/vs so
//   they line up with a renderer's registered RGB output.

module vga_timing_gen #(
  parameter int unsigned H_VISIBLE = 640,
  parameter int unsigned H_FRONT   = 16,
  parameter int unsigned H_SYNC    = 96,
  parameter int unsigned H_BACK    = 48,
  parameter int unsigned V_VISIBLE = 480,
  parameter int unsigned V_FRONT   = 10,
  parameter int unsigned V_SYNC    = 2,
  parameter int unsigned V_BACK    = 33
) (
  input  logic       vga_clk,
  input  logic       reset_n,
  output logic [9:0] DrawX,
  output logic [9:0] DrawY,
  output logic       blank,
  output logic       hs,
  output logic       vs,
  output logic       line_start,
  output logic       frame_start
);

  localparam int unsigned H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  // 10-bit copies of the boundaries so every compare is width-matched.
  localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS_END  = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS_END  = 10'(V_VISIBLE);
  localparam logic [9:0] HS_START   = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] HS_END     = 10'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [9:0] VS_START   = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] VS_END     = 10'(V_VISIBLE + V_FRONT + V_SYNC);

  logic [9:0] h_cnt_q, h_cnt_d;
  logic [9:0] v_cnt_q, v_cnt_d;

  logic [9:0] draw_x_q, draw_y_q;
  logic       blank_q, blank_d;
  logic       hs_q, hs_d;
  logic       vs_q, vs_d;
  logic       line_start_q, line_start_d;
  logic       frame_start_q, frame_start_d;

  logic       h_last, v_last;

  // Counter advance: wrap the column at end of line, step the row only on
  // the wrap, and wrap both together at end of frame.
  always_comb begin
    h_last  = (h_cnt_q == H_LAST);
    v_last  = (v_cnt_q == V_LAST);
    h_cnt_d = h_last ? 10'd0 : h_cnt_q + 10'd1;
    v_cnt_d = v_cnt_q;
    if (h_last) begin
      v_cnt_d = v_last ? 10'd0 : v_cnt_q + 10'd1;
    end
  end

  // Decode from the current counter value; the result is registered so the
  // ports carry the decode of the coordinate they also report.
  always_comb begin
    blank_d       = (h_cnt_q < H_VIS_END) && (v_cnt_q < V_VIS_END);
    hs_d          = !((h_cnt_q >= HS_START) && (h_cnt_q < HS_END));
    vs_d          = !((v_cnt_q >= VS_START) && (v_cnt_q < VS_END));
    line_start_d  = (h_cnt_q == 10'd0);
    frame_start_d = (h_cnt_q == 10'd0) && (v_cnt_q == 10'd0);
  end

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      h_cnt_q       <= 10'd0;
      v_cnt_q       <= 10'd0;
      draw_x_q      <= 10'd0;
      draw_y_q      <= 10'd0;
      blank_q       <= 1'b0;
      hs_q          <= 1'b1;
      vs_q          <= 1'b1;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      h_cnt_q       <= h_cnt_d;
      v_cnt_q       <= v_cnt_d;
      draw_x_q      <= h_cnt_q;
      draw_y_q      <= v_cnt_q;
      blank_q       <= blank_d;
      hs_q          <= hs_d;
      vs_q          <= vs_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
    end
  end

`ifdef VGA_SYNC_DELAY_EN
  // Extra sync stage; idles high so the connector sees no spurious pulse
  // coming out of reset.
  logic hs_dly_q, vs_dly_q;

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      hs_dly_q <= 1'b1;
      vs_dly_q <= 1'b1;
    end else begin
      hs_dly_q <= hs_q;
      vs_dly_q <= vs_q;
    end
  end

  assign hs = hs_dly_q;
  assign vs = vs_dly_q;
`else
  assign hs = hs_q;
  assign vs = vs_q;
`endif

  assign DrawX       = draw_x_q;
  assign DrawY       = draw_y_q;
  assign blank       = blank_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - directed self-checking bench for vga_timing_gen
//
// Instance a uses the 640x480 timing for line-level checks; instance b uses a
// 16x12 raster so whole-frame behaviour fits in a short run.

module tb_vga_timing_gen;

`ifdef VGA_SYNC_DELAY_EN
  localparam int LAG = 1;
`else
  localparam int LAG = 0;
`endif

  logic vga_clk = 1'b0;
  always #5 vga_clk = ~vga_clk;

  logic       rst_a_n, rst_b_n;
  logic [9:0] a_x, a_y, b_x, b_y;
  logic       a_blank, a_hs, a_vs, a_ls, a_fs;
  logic       b_blank, b_hs, b_vs, b_ls, b_fs;

  vga_timing_gen dut_a (
    .vga_clk     (vga_clk),
    .reset_n     (rst_a_n),
    .DrawX       (a_x),
    .DrawY       (a_y),
    .blank       (a_blank),
    .hs          (a_hs),
    .vs          (a_vs),
    .line_start  (a_ls),
    .frame_start (a_fs)
  );

  vga_timing_gen #(
    .H_VISIBLE (8), .H_FRONT (2), .H_SYNC (3), .H_BACK (3),
    .V_VISIBLE (6), .V_FRONT (2), .V_SYNC (2), .V_BACK (2)
  ) dut_b (
    .vga_clk     (vga_clk),
    .reset_n     (rst_b_n),
    .DrawX       (b_x),
    .DrawY       (b_y),
    .blank       (b_blank),
    .hs          (b_hs),
    .vs          (b_vs),
    .line_start  (b_ls),
    .frame_start (b_fs)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  int hs_low_cnt, hs_first, a_blank_cnt;
  int b_blank_cnt, b_vs_cnt, b_vs_first, b_fs_cnt, b_ls_cnt, b_hs_cnt;

  initial begin
    int k, x, y;
    rst_a_n = 1'b0;
    rst_b_n = 1'b0;

    // Reset held for 5 clocks: both instances at reset values throughout.
    repeat (5) begin
      @(negedge vga_clk);
      chk("rst_x", a_x, 0);
      chk("rst_y", a_y, 0);
      chk("rst_blank", a_blank, 0);
      chk("rst_hs", a_hs, 1);
      chk("rst_vs", a_vs, 1);
      chk("rst_ls", a_ls, 0);
      chk("rst_fs", a_fs, 0);
      chk("rst_b_x", b_x, 0);
      chk("rst_b_hs", b_hs, 1);
      chk("rst_b_fs", b_fs, 0);
    end

    // Full 640x480 line plus the first clock of the next line.
    rst_a_n = 1'b1;
    hs_low_cnt = 0; hs_first = -1; a_blank_cnt = 0;
    for (int i = 0; i <= 800; i++) begin
      @(negedge vga_clk);
      x = i % 800;
      y = i / 800;
      chk("a_x", a_x, x);
      chk("a_y", a_y, y);
      chk("a_ls", a_ls, (x == 0) ? 1 : 0);
      chk("a_fs", a_fs, (i == 0) ? 1 : 0);
      chk("a_blank", a_blank, (x < 640) ? 1 : 0);
      chk("a_vs", a_vs, 1);
      k = i - LAG;
      chk("a_hs", a_hs, (k < 0) ? 1 : (((k % 800) >= 656 && (k % 800) < 752) ? 0 : 1));
      if (i < 800) begin
        if (a_hs === 1'b0) begin
          if (hs_first < 0) hs_first = i;
          hs_low_cnt++;
        end
        if (a_blank === 1'b1) a_blank_cnt++;
      end
    end
    chk("a_hs_low_count", hs_low_cnt, 96);
    chk("a_hs_first_low", hs_first, 656 + LAG);
    chk("a_blank_count", a_blank_cnt, 640);

    // Whole small frame (192 clocks) plus the wrap back to (0,0).
    rst_b_n = 1'b1;
    b_blank_cnt = 0; b_vs_cnt = 0; b_vs_first = -1; b_fs_cnt = 0; b_ls_cnt = 0; b_hs_cnt = 0;
    for (int i = 0; i <= 192; i++) begin
      @(negedge vga_clk);
      x = i % 16;
      y = (i / 16) % 12;
      chk("b_x", b_x, x);
      chk("b_y", b_y, y);
      chk("b_blank", b_blank, (x < 8 && y < 6) ? 1 : 0);
      chk("b_ls", b_ls, (x == 0) ? 1 : 0);
      chk("b_fs", b_fs, (x == 0 && y == 0) ? 1 : 0);
      k = i - LAG;
      chk("b_hs", b_hs, (k < 0) ? 1 : (((k % 16) >= 10 && (k % 16) < 13) ? 0 : 1));
      chk("b_vs", b_vs, (k < 0) ? 1 : ((((k / 16) % 12) >= 8 && ((k / 16) % 12) < 10) ? 0 : 1));
      if (i < 192) begin
        if (b_blank === 1'b1) b_blank_cnt++;
        if (b_fs === 1'b1) b_fs_cnt++;
        if (b_ls === 1'b1) b_ls_cnt++;
        if (b_hs === 1'b0) b_hs_cnt++;
        if (b_vs === 1'b0) begin
          if (b_vs_first < 0) b_vs_first = i;
          b_vs_cnt++;
        end
      end
    end
    chk("b_blank_count", b_blank_cnt, 48);
    chk("b_vs_low_count", b_vs_cnt, 32);
    chk("b_vs_first_low", b_vs_first, 128 + LAG);
    chk("b_fs_count", b_fs_cnt, 1);
    chk("b_ls_count", b_ls_cnt, 12);
    chk("b_hs_low_count", b_hs_cnt, 36);

    // Advance to (5,3) of the second frame, then reset asynchronously.
    repeat (53) @(negedge vga_clk);
    chk("b_pre_rst_x", b_x, 5);
    chk("b_pre_rst_y", b_y, 3);
    chk("b_pre_rst_blank", b_blank, 1);
    #1;
    rst_b_n = 1'b0;
    #1;
    chk("async_x", b_x, 0);
    chk("async_y", b_y, 0);
    chk("async_blank", b_blank, 0);
    chk("async_hs", b_hs, 1);
    chk("async_vs", b_vs, 1);
    chk("async_ls", b_ls, 0);
    chk("async_fs", b_fs, 0);
    repeat (2) begin
      @(negedge vga_clk);
      chk("held_x", b_x, 0);
      chk("held_fs", b_fs, 0);
    end
    rst_b_n = 1'b1;
    @(negedge vga_clk);
    chk("restart_x", b_x, 0);
    chk("restart_y", b_y, 0);
    chk("restart_fs", b_fs, 1);
    chk("restart_ls", b_ls, 1);
    chk("restart_blank", b_blank, 1);
    @(negedge vga_clk);
    chk("restart_x1", b_x, 1);
    chk("restart_fs1", b_fs, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
